// File: rtl/fetch_unit_pkg.sv
// Shared fetch-unit definitions: next-PC selects, FSM states, NOP word.
// Also holds the branch offset helper used by the next-PC logic.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    NPC_PLUS_4 = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_HOLD   = 2'd3
  } npc_op_e;

  typedef enum logic {
    FU_IDLE = 1'b0,
    FU_BUSY = 1'b1
  } fu_state_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  function automatic logic [31:0] branch_off(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_npc_calc.sv
// Combinational next-PC: PC+4, PC-relative branch, region jump or hold.
// Only the low 26 instruction bits matter here.
module npc_calc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr_idx,
  input  logic [1:0]  npc_op,
  output logic [31:0] npc
);

  always_comb begin
    npc = pc;
    case (npc_op)
      NPC_PLUS_4: npc = pc + 32'd4;
      NPC_BRANCH: npc = pc + branch_off(instr_idx[15:0]);
      NPC_JUMP:   npc = {pc[31:28], instr_idx, 2'b00};
      NPC_HOLD:   npc = pc;
      default:    npc = pc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Multi-cycle MIPS fetch unit: PC/IR ownership, req/ack instruction fetch,
// fetch stall and a sticky watchdog error for missing acknowledges.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWr,
  input  logic        IRWr,
  input  logic [1:0]  NPCOp,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  input  logic        im_ack,
  output logic        fetch_busy,
  output logic        fetch_err,
  output logic [31:0] PC,
  output logic [31:0] IR,
  output logic [5:0]  Op,
  output logic [5:0]  Func,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] Imm16
);

  localparam int CW = $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] TMAX = CW'(ACK_TIMEOUT - 1);

  fu_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        err_q, err_d;
  logic [31:0] npc;
  logic        busy;
  logic        ack_hit;
  logic        timeout;

  assign busy    = (state_q == FU_BUSY);
  assign ack_hit = busy & im_ack;
  assign timeout = busy & ~im_ack & (cnt_q == TMAX);

  npc_calc u_npc (
    .pc        (pc_q),
    .instr_idx (ir_q[25:0]),
    .npc_op    (NPCOp),
    .npc       (npc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FU_IDLE;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      ir_q    <= NOP_WORD;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FU_IDLE: if (IRWr) state_d = FU_BUSY;
      FU_BUSY: if (ack_hit | timeout) state_d = FU_IDLE;
      default: state_d = FU_IDLE;
    endcase
  end

  always_comb begin
    im_req     = busy;
    fetch_busy = (~busy & IRWr) | (busy & ~im_ack & ~timeout);
  end

  // PC only moves outside a fetch, except the PC+4 on the ack edge
  always_comb begin
    cnt_d = '0;
    pc_d  = pc_q;
    ir_d  = ir_q;
    err_d = err_q;
    if (!busy) begin
      if (!IRWr && PCWr) pc_d = npc;
    end else if (ack_hit) begin
      ir_d = im_rdata;
      if (PCWr && NPCOp == NPC_PLUS_4) pc_d = npc;
    end else if (timeout) begin
      ir_d  = NOP_WORD;
      err_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign im_addr   = pc_q;
  assign PC        = pc_q;
  assign IR        = ir_q;
  assign fetch_err = err_q;
  assign Op        = ir_q[31:26];
  assign rs        = ir_q[25:21];
  assign rt        = ir_q[20:16];
  assign rd        = ir_q[15:11];
  assign Func      = ir_q[5:0];
  assign Imm16     = ir_q[15:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_fetch_unit;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst, PCWr, IRWr, im_ack;
  logic [1:0]  NPCOp;
  logic [31:0] im_rdata;
  logic        im_req, fetch_busy, fetch_err;
  logic [31:0] im_addr, PC, IR;
  logic [5:0]  Op, Func;
  logic [4:0]  rs, rt, rd;
  logic [15:0] Imm16;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_3000), .ACK_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .PCWr(PCWr), .IRWr(IRWr), .NPCOp(NPCOp),
    .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata),
    .im_ack(im_ack), .fetch_busy(fetch_busy), .fetch_err(fetch_err),
    .PC(PC), .IR(IR), .Op(Op), .Func(Func), .rs(rs), .rt(rt), .rd(rd),
    .Imm16(Imm16)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a fetch is pending or not, plus cycles waited.
  bit          m_valid = 1'b0;
  bit          m_busy, m_err;
  int          m_wait;
  logic [31:0] m_pc, m_ir;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_pc = 32'h0000_3000;
      m_ir = 32'h0;
      m_busy = 1'b0;
      m_err = 1'b0;
      m_wait = 0;
    end else if (m_valid) begin
      if (!m_busy) begin
        if (IRWr) begin
          m_busy = 1'b1;
          m_wait = 0;
        end else if (PCWr) begin
          case (NPCOp)
            2'd0: m_pc = m_pc + 32'd4;
            2'd1: m_pc = m_pc + 32'(int'($signed(m_ir[15:0])) * 4);
            2'd2: m_pc = (m_pc & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) * 4);
            default: ;
          endcase
        end
      end else if (im_ack) begin
        m_ir = im_rdata;
        if (PCWr && NPCOp == 2'd0) m_pc = m_pc + 32'd4;
        m_busy = 1'b0;
      end else if (m_wait == T - 1) begin
        m_ir = 32'h0;
        m_err = 1'b1;
        m_busy = 1'b0;
      end else begin
        m_wait++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      logic exp_busy;
      exp_busy = m_busy ? (!im_ack && m_wait != T - 1) : IRWr;
      chk("pc", PC, m_pc);
      chk("ir", IR, m_ir);
      chk("im_addr", im_addr, m_pc);
      chk("im_req", 32'(im_req), 32'(m_busy));
      chk("fetch_err", 32'(fetch_err), 32'(m_err));
      chk("fetch_busy", 32'(fetch_busy), 32'(exp_busy));
      chk("fields", {5'd0, Op, rs, rt, rd, Func},
          {5'd0, m_ir[31:11], m_ir[5:0]});
      chk("imm16", {16'd0, Imm16}, {16'd0, m_ir[15:0]});
    end
  end

  logic last_busy;

  task automatic step(input bit r, input bit iw, input bit pw,
                      input logic [1:0] op, input bit ak,
                      input logic [31:0] rdat);
    rst = r; IRWr = iw; PCWr = pw; NPCOp = op;
    im_ack = ak; im_rdata = rdat;
    #1 last_busy = fetch_busy;
    @(posedge clk);
    #2;
  endtask

  task automatic fetch(input logic [31:0] w);
    step(0, 1, 1, 2'd0, 0, 32'h0);
    step(0, 0, 1, 2'd0, 1, w);
  endtask

  initial begin
    int nb;
    int pct;
    step(1, 0, 0, 2'd0, 0, 32'h0);
    step(1, 0, 0, 2'd0, 0, 32'h0);
    chk("rst_pc", PC, 32'h0000_3000);
    chk("rst_ir", IR, 32'h0);
    chk("rst_req", 32'(im_req), 32'h0);
    chk("rst_err", 32'(fetch_err), 32'h0);

    nb = 0;
    step(0, 1, 1, 2'd0, 0, 32'h0); nb += int'(last_busy);
    chk("t1_req", 32'(im_req), 32'h1);
    chk("t1_addr", im_addr, 32'h0000_3000);
    step(0, 1, 1, 2'd0, 0, 32'h0); nb += int'(last_busy);
    step(0, 1, 1, 2'd0, 1, 32'h3402_0005); nb += int'(last_busy);
    chk("t1_ir", IR, 32'h3402_0005);
    chk("t1_op", 32'(Op), 32'h0D);
    chk("t1_pc", PC, 32'h0000_3004);
    chk("t1_busy_cycles", 32'(nb), 32'd2);
    step(0, 0, 0, 2'd3, 0, 32'h0);

    step(1, 0, 0, 2'd0, 0, 32'h0);
    nb = 0;
    step(0, 1, 1, 2'd0, 0, 32'h0); nb += int'(last_busy);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 1, 2'd0, 0, 32'h0); nb += int'(last_busy);
      chk("t2_req", 32'(im_req), 32'h1);
      chk("t2_addr", im_addr, 32'h0000_3000);
      chk("t2_pc", PC, 32'h0000_3000);
    end
    step(0, 1, 1, 2'd0, 1, 32'h1111_2222); nb += int'(last_busy);
    chk("t2_busy_cycles", 32'(nb), 32'd6);
    chk("t2_pc_after", PC, 32'h0000_3004);
    chk("t2_ir", IR, 32'h1111_2222);

    fetch(32'h1000_FFFF);
    chk("t3_pc_pre", PC, 32'h0000_3008);
    step(0, 0, 0, 2'd1, 0, 32'h0);
    chk("t3_nowr", PC, 32'h0000_3008);
    step(0, 0, 1, 2'd1, 0, 32'h0);
    chk("t3_branch", PC, 32'h0000_3004);

    fetch(32'h0);
    fetch(32'h0);
    fetch(32'h0C00_0C10);
    chk("t4_link", PC, 32'h0000_3010);
    step(0, 0, 1, 2'd2, 0, 32'h0);
    chk("t4_jump", PC, 32'h0000_3040);

    step(0, 1, 1, 2'd0, 0, 32'h0);
    for (int k = 0; k < T; k++) begin
      step(0, 0, 1, (k % 2 == 1) ? 2'd1 : 2'd0, 0, 32'h0);
      chk("t5_req", 32'(im_req), (k < T - 1) ? 32'h1 : 32'h0);
    end
    chk("t5_ir", IR, 32'h0);
    chk("t5_err", 32'(fetch_err), 32'h1);
    chk("t5_pc", PC, 32'h0000_3040);
    step(0, 0, 0, 2'd3, 1, 32'hDEAD_BEEF);
    chk("t5_late_ir", IR, 32'h0);
    chk("t5_late_pc", PC, 32'h0000_3040);
    repeat (3) step(0, 0, 0, 2'd3, 0, 32'h0);
    chk("t5_sticky", 32'(fetch_err), 32'h1);

    step(1, 0, 0, 2'd0, 0, 32'h0);
    chk("wr_err_clr", 32'(fetch_err), 32'h0);
    fetch(32'h1000_F3FE);
    step(0, 0, 1, 2'd1, 0, 32'h0);
    chk("wr_neg", PC, 32'hFFFF_FFFC);
    step(0, 0, 1, 2'd0, 0, 32'h0);
    chk("wr_wrap", PC, 32'h0);

    step(1, 0, 0, 2'd0, 0, 32'h0);
    step(0, 1, 1, 2'd0, 0, 32'h0);
    step(0, 0, 1, 2'd0, 0, 32'h0);
    step(1, 0, 1, 2'd0, 0, 32'h0);
    chk("t6_req", 32'(im_req), 32'h0);
    chk("t6_pc", PC, 32'h0000_3000);
    chk("t6_ir", IR, 32'h0);
    step(0, 0, 0, 2'd0, 1, 32'h1234_5678);
    chk("t6_ack_ir", IR, 32'h0);
    chk("t6_ack_pc", PC, 32'h0000_3000);

    for (int i = 0; i < 4000; i++) begin
      case ((i / 500) % 3)
        0: pct = 40;
        1: pct = 3;
        default: pct = 15;
      endcase
      step(($urandom % 250) == 0,
           ($urandom % 100) < 20,
           1'($urandom % 2),
           2'($urandom % 4),
           im_req ? (int'($urandom % 100) < pct) : (($urandom % 100) < 4),
           $urandom);
    end
    step(0, 0, 0, 2'd3, 0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
